core_control: RTL

Multi-cycle control FSM for the RV32I core and the initiating side of the ALU interface. It sequences fetch, decode, execute, memory and writeback. Each cycle it drives the ALU operation code and the operand selects, and it uses the ALU's bit-0 result to resolve branches. It also owns the single memory request/acknowledge handshake shared by instruction fetch and load/store.

---
 rtl/core_control_pkg.sv | 80 ++++++++
 rtl/core_control_alu_op_decode.sv | 49 ++++
 rtl/core_control.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/core_control_pkg.sv
// Shared enums and constants for the RV32I multi-cycle control path.
// Holds the ALU operation codes, FSM state encodings, datapath select
// encodings, RV32I major opcodes and the class used to drive alu_op_decode.
package core_control_pkg;

   typedef enum logic [3:0] {
      ALU_OP_ZERO = 4'd0,
      ALU_OP_ADD  = 4'd1,
      ALU_OP_SUB  = 4'd2,
      ALU_OP_SLL  = 4'd3,
      ALU_OP_SLT  = 4'd4,
      ALU_OP_SLTU = 4'd5,
      ALU_OP_XOR  = 4'd6,
      ALU_OP_SRL  = 4'd7,
      ALU_OP_SRA  = 4'd8,
      ALU_OP_OR   = 4'd9,
      ALU_OP_AND  = 4'd10,
      ALU_OP_SEQ  = 4'd11
   } alu_op_t;

   // FSM state encodings kept as plain constants for legacy tools.
   typedef logic [2:0] state_t;
   localparam state_t ST_RESET  = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DECODE = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_MEM    = 3'd4;
   localparam state_t ST_WB     = 3'd5;
   localparam state_t ST_TRAP   = 3'd6;

   typedef enum logic [1:0] {
      PC_SRC_PLUS4  = 2'd0,
      PC_SRC_TARGET = 2'd1,
      PC_SRC_ALU    = 2'd2
   } pc_src_t;

   typedef enum logic [1:0] {
      LHS_RS1  = 2'd0,
      LHS_PC   = 2'd1,
      LHS_ZERO = 2'd2
   } lhs_sel_t;

   typedef enum logic [1:0] {
      RHS_RS2  = 2'd0,
      RHS_IMM  = 2'd1,
      RHS_FOUR = 2'd2
   } rhs_sel_t;

   typedef enum logic [1:0] {
      WB_ALU   = 2'd0,
      WB_MEM   = 2'd1,
      WB_PLUS4 = 2'd2
   } wb_sel_t;

   typedef enum logic [1:0] {
      ALU_CLASS_OP     = 2'd0,
      ALU_CLASS_OP_IMM = 2'd1,
      ALU_CLASS_BRANCH = 2'd2,
      ALU_CLASS_OTHER  = 2'd3
   } alu_class_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   function automatic logic is_legal_opcode(input logic [6:0] opcode);
      unique case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_legal_opcode = 1'b1;
         default:                                 is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/core_control_alu_op_decode.sv
// Combinational ALU operation decode.
// Ports:
//   alu_class_i  instruction class (OP, OP-IMM, BRANCH, other)
//   funct3_i     instr[14:12]
//   funct7_b5_i  instr[30]
//   alu_op_o     ALU operation for EXEC
//   br_invert_o  1 when the branch is taken on a zero compare result
module alu_op_decode
   import core_control_pkg::*;
(
   input  alu_class_t  alu_class_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7_b5_i,
   output alu_op_t     alu_op_o,
   output logic        br_invert_o
);

   always_comb begin
      alu_op_o    = ALU_OP_ADD;
      br_invert_o = 1'b0;
      unique case (alu_class_i)
         ALU_CLASS_OP, ALU_CLASS_OP_IMM: begin
            unique case (funct3_i)
               // OP-IMM has no SUBI: instr[30] is immediate data there.
               3'b000: alu_op_o = (alu_class_i == ALU_CLASS_OP && funct7_b5_i) ?
                                  ALU_OP_SUB : ALU_OP_ADD;
               3'b001: alu_op_o = ALU_OP_SLL;
               3'b010: alu_op_o = ALU_OP_SLT;
               3'b011: alu_op_o = ALU_OP_SLTU;
               3'b100: alu_op_o = ALU_OP_XOR;
               3'b101: alu_op_o = funct7_b5_i ? ALU_OP_SRA : ALU_OP_SRL;
               3'b110: alu_op_o = ALU_OP_OR;
               default: alu_op_o = ALU_OP_AND;
            endcase
         end
         ALU_CLASS_BRANCH: begin
            unique case (funct3_i[2:1])
               2'b10:   alu_op_o = ALU_OP_SLT;
               2'b11:   alu_op_o = ALU_OP_SLTU;
               default: alu_op_o = ALU_OP_SEQ;
            endcase
            // BNE, BGE, BGEU are the odd funct3 codes.
            br_invert_o = funct3_i[0];
         end
         default: alu_op_o = ALU_OP_ADD;
      endcase
   end

endmodule

// File: rtl/core_control.sv
// Multi-cycle RV32I control FSM: FETCH, DECODE, EXEC, MEM, WB (+ RESET, TRAP).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr             instruction register contents (valid from DECODE)
//   alu_out_bit0      ALU result bit 0, resolves branches in EXEC
//   mem_ack           memory transfer complete
//   mem_req/mem_we/mem_addr_sel   shared fetch/load/store handshake
//   ir_we, pc_we, pc_src          instruction register and PC update
//   alu_op, alu_lhs_sel, alu_rhs_sel   ALU control
//   rf_we, rf_wdata_sel           register file writeback
//   trap              illegal opcode seen, held until reset
module core_control
   import core_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        alu_out_bit0,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output pc_src_t     pc_src,
   output alu_op_t     alu_op,
   output lhs_sel_t    alu_lhs_sel,
   output rhs_sel_t    alu_rhs_sel,
   output logic        rf_we,
   output wb_sel_t     rf_wdata_sel,
   output logic        trap
);

   state_t     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   alu_class_t alu_class;
   alu_op_t    dec_alu_op;
   logic       br_invert;
   logic       br_taken;
   logic       is_store;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign is_store     = (opcode == OPC_STORE);
   assign br_taken     = alu_out_bit0 ^ br_invert;
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   always_comb begin
      unique case (opcode)
         OPC_OP:     alu_class = ALU_CLASS_OP;
         OPC_OP_IMM: alu_class = ALU_CLASS_OP_IMM;
         OPC_BRANCH: alu_class = ALU_CLASS_BRANCH;
         default:    alu_class = ALU_CLASS_OTHER;
      endcase
   end

   alu_op_decode u_alu_op_decode (
      .alu_class_i (alu_class),
      .funct3_i    (funct3),
      .funct7_b5_i (instr[30]),
      .alu_op_o    (dec_alu_op),
      .br_invert_o (br_invert)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_FETCH;
         ST_FETCH:  if (mem_ack) state_d = ST_DECODE;
         ST_DECODE: state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
               state_d = ST_MEM;
            end else if (opcode == OPC_BRANCH) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM:    if (mem_ack) state_d = is_store ? ST_FETCH : ST_WB;
         ST_WB:     state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs decode state_q, so reset forces them (mem_req included) low at once.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SRC_PLUS4;
      alu_op       = ALU_OP_ZERO;
      alu_lhs_sel  = LHS_RS1;
      alu_rhs_sel  = RHS_RS2;
      rf_we        = 1'b0;
      rf_wdata_sel = WB_ALU;
      trap         = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ack;
         end
         ST_DECODE: begin
            // Datapath captures PC + imm as the branch/JAL target.
            alu_op      = ALU_OP_ADD;
            alu_lhs_sel = LHS_PC;
            alu_rhs_sel = RHS_IMM;
         end
         ST_EXEC: begin
            case (opcode)
               OPC_OP: begin
                  alu_op = dec_alu_op;
               end
               OPC_OP_IMM: begin
                  alu_op      = dec_alu_op;
                  alu_rhs_sel = RHS_IMM;
               end
               OPC_LOAD, OPC_STORE: begin
                  alu_op      = ALU_OP_ADD;
                  alu_rhs_sel = RHS_IMM;
               end
               OPC_BRANCH: begin
                  alu_op = dec_alu_op;
                  pc_we  = 1'b1;
                  pc_src = br_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
               end
               OPC_JAL: begin
                  pc_we  = 1'b1;
                  pc_src = PC_SRC_TARGET;
               end
               OPC_JALR: begin
                  alu_op      = ALU_OP_ADD;
                  alu_rhs_sel = RHS_IMM;
                  pc_we       = 1'b1;
                  pc_src      = PC_SRC_ALU;
               end
               OPC_LUI: begin
                  alu_op      = ALU_OP_ADD;
                  alu_lhs_sel = LHS_ZERO;
                  alu_rhs_sel = RHS_IMM;
               end
               OPC_AUIPC: begin
                  alu_op      = ALU_OP_ADD;
                  alu_lhs_sel = LHS_PC;
                  alu_rhs_sel = RHS_IMM;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            // A store retires on its ack cycle; a load retires in WB.
            pc_we        = is_store & mem_ack;
         end
         ST_WB: begin
            rf_we = 1'b1;
            if (opcode == OPC_LOAD) begin
               rf_wdata_sel = WB_MEM;
            end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
               rf_wdata_sel = WB_PLUS4;
            end
            // Jumps already updated the PC in EXEC.
            pc_we = !(opcode == OPC_JAL || opcode == OPC_JALR);
         end
         ST_TRAP: trap = 1'b1;
         default: ;
      endcase
   end

endmodule
